// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the paced SPI DAC transmitter.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4
    } state_t;

    // Cycles for which busy stays high per frame, including the CS-high hold.
    function automatic int frame_cycles(input int data_w, input int clk_div);
        return (2 * data_w + 1) * clk_div;
    endfunction

endpackage

// File: rtl/dac_spi_tx_timer.sv
// Free-running sample-rate timer: one registered tick per SAMPLE_DIV cycles while enabled.
module dac_sample_timer #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic enable,
    output logic sample_tick
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [TW-1:0] timer_r;
    logic          tick_r;

    // Timer count and tick register; disabling parks the count at zero.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            timer_r <= '0;
            tick_r  <= 1'b0;
        end else if (!enable) begin
            timer_r <= '0;
            tick_r  <= 1'b0;
        end else if (timer_r == TW'(SAMPLE_DIV - 1)) begin
            timer_r <= '0;
            tick_r  <= 1'b1;
        end else begin
            timer_r <= timer_r + TW'(1);
            tick_r  <= 1'b0;
        end
    end

    assign sample_tick = tick_r;

endmodule

// File: rtl/dac_spi_tx.sv
// Paced SPI (mode 0) transmitter for a 16-bit DAC with overrun counting.
// Optional macro DAC_SPI_TX_OFFSET_BINARY_EN inverts the sample MSB before shifting.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 1000,
    parameter int OVR_W      = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] dac_data,
    output logic              dac_sclk,
    output logic              dac_cs_n,
    output logic              dac_mosi,
    output logic              busy,
    output logic              sample_tick,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t            state_r, state_s;
    logic [DCW-1:0]    div_r, div_s;
    logic [BCW-1:0]    bit_r, bit_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic              sclk_r, sclk_s;
    logic              cs_n_r, cs_n_s;
    logic              mosi_r, mosi_s;
    logic              busy_r;
    logic [OVR_W-1:0]  ovr_r, ovr_s;
    logic [DATA_W-1:0] word_s;
    logic              div_done_s;

    dac_sample_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .enable      (enable),
        .sample_tick (sample_tick)
    );

`ifdef DAC_SPI_TX_OFFSET_BINARY_EN
    assign word_s = {~dac_data[DATA_W-1], dac_data[DATA_W-2:0]};
`else
    assign word_s = dac_data;
`endif

    assign div_done_s = (div_r == DCW'(CLK_DIV - 1));

    // Next-state, shift and pin logic; shreg holds the bits still to be sent, MSB aligned.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        bit_s   = bit_r;
        shreg_s = shreg_r;
        sclk_s  = sclk_r;
        cs_n_s  = cs_n_r;
        mosi_s  = mosi_r;
        ovr_s   = ovr_r;

        if (state_r == IDLE || div_done_s) begin
            div_s = '0;
        end else begin
            div_s = div_r + DCW'(1);
        end

        case (state_r)
            IDLE: begin
                if (sample_tick) begin
                    shreg_s = {word_s[DATA_W-2:0], 1'b0};
                    mosi_s  = word_s[DATA_W-1];
                    cs_n_s  = 1'b0;
                    bit_s   = '0;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP, SHIFT_LO: begin
                if (div_done_s) begin
                    sclk_s  = 1'b1;
                    state_s = SHIFT_HI;
                end else begin
                    state_s = state_r;
                end
            end
            SHIFT_HI: begin
                if (!div_done_s) begin
                    state_s = SHIFT_HI;
                end else if (bit_r == BCW'(DATA_W - 1)) begin
                    sclk_s  = 1'b0;
                    cs_n_s  = 1'b1;
                    mosi_s  = 1'b0;
                    state_s = HOLD;
                end else begin
                    sclk_s  = 1'b0;
                    mosi_s  = shreg_r[DATA_W-1];
                    shreg_s = {shreg_r[DATA_W-2:0], 1'b0};
                    bit_s   = bit_r + BCW'(1);
                    state_s = SHIFT_LO;
                end
            end
            HOLD: begin
                if (div_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                sclk_s  = 1'b0;
                cs_n_s  = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase

        // A tick landing in any non-idle cycle (including the last HOLD cycle) is dropped.
        if (sample_tick && state_r != IDLE && ovr_r != {OVR_W{1'b1}}) begin
            ovr_s = ovr_r + OVR_W'(1);
        end else begin
            ovr_s = ovr_r;
        end
    end

    // State and registered pin drivers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r <= IDLE;
            div_r   <= '0;
            bit_r   <= '0;
            shreg_r <= '0;
            sclk_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            ovr_r   <= '0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            shreg_r <= shreg_s;
            sclk_r  <= sclk_s;
            cs_n_r  <= cs_n_s;
            mosi_r  <= mosi_s;
            busy_r  <= (state_s != IDLE);
            ovr_r   <= ovr_s;
        end
    end

    assign dac_sclk    = sclk_r;
    assign dac_cs_n    = cs_n_r;
    assign dac_mosi    = mosi_r;
    assign busy        = busy_r;
    assign overrun_cnt = ovr_r;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame shape, pacing, overrun, reset, enable and data-format checks.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c, en_a, en_b, en_c;
    logic [15:0] data_a, data_b, data_c;
    logic        sclk_a, cs_n_a, mosi_a, busy_a, tick_a;
    logic        sclk_b, cs_n_b, mosi_b, busy_b, tick_b;
    logic        sclk_c, cs_n_c, mosi_c, busy_c, tick_c;
    logic [7:0]  ovr_a, ovr_b;
    logic [1:0]  ovr_c;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int ticks_b  = 0;

    dac_spi_tx #(.DATA_W(16), .CLK_DIV(2), .SAMPLE_DIV(100), .OVR_W(8)) u_a (
        .clk_clk(clk), .reset_reset(rst_a), .enable(en_a), .dac_data(data_a),
        .dac_sclk(sclk_a), .dac_cs_n(cs_n_a), .dac_mosi(mosi_a), .busy(busy_a),
        .sample_tick(tick_a), .overrun_cnt(ovr_a));

    dac_spi_tx #(.DATA_W(16), .CLK_DIV(2), .SAMPLE_DIV(50), .OVR_W(8)) u_b (
        .clk_clk(clk), .reset_reset(rst_b), .enable(en_b), .dac_data(data_b),
        .dac_sclk(sclk_b), .dac_cs_n(cs_n_b), .dac_mosi(mosi_b), .busy(busy_b),
        .sample_tick(tick_b), .overrun_cnt(ovr_b));

    dac_spi_tx #(.DATA_W(16), .CLK_DIV(2), .SAMPLE_DIV(50), .OVR_W(2)) u_c (
        .clk_clk(clk), .reset_reset(rst_c), .enable(en_c), .dac_data(data_c),
        .dac_sclk(sclk_c), .dac_cs_n(cs_n_c), .dac_mosi(mosi_c), .busy(busy_c),
        .sample_tick(tick_c), .overrun_cnt(ovr_c));

    function automatic logic [15:0] sent(input logic [15:0] d);
`ifdef DAC_SPI_TX_OFFSET_BINARY_EN
        return d ^ 16'h8000;
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; instance B is stopped after its 21st tick (10 dropped).
    task automatic step();
        @(negedge clk);
        cyc++;
        if (tick_b === 1'b1) begin
            ticks_b++;
            if (ticks_b == 21) en_b = 1'b0;
        end
    endtask

    task automatic wait_tick_a(input string tag);
        int guard = 0;
        while (tick_a !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        check(tag, 32'(guard < 400), 32'd1);
    endtask

    // Observe one frame on instance A; mode 1 changes data, 2 drops enable, 3 asserts reset at act_bit.
    task automatic capture(input int mode, input int act_bit, input logic [15:0] new_data,
                           output logic [15:0] word, output int cs_low, output int rises,
                           output int busy_n, output int ticks_in);
        int   guard     = 0;
        logic prev_sclk = 1'b0;
        word = '0; cs_low = 0; rises = 0; busy_n = 0; ticks_in = 0;
        while (busy_a !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        check("frame_start", 32'(guard < 400), 32'd1);
        while (busy_a === 1'b1 && busy_n < 200) begin
            busy_n++;
            if (cs_n_a === 1'b0) cs_low++;
            if (tick_a === 1'b1) ticks_in++;
            if (sclk_a === 1'b1 && prev_sclk === 1'b0) begin
                word = {word[14:0], mosi_a};
                rises++;
                if (rises == act_bit + 1) begin
                    if (mode == 1) data_a = new_data;
                    else if (mode == 2) en_a = 1'b0;
                    else if (mode == 3) begin
                        rst_a = 1'b1;
                        return;
                    end
                end
            end
            prev_sclk = sclk_a;
            step();
        end
    endtask

    initial begin
        logic [15:0] w;
        int csl, rs, bn, tk, c0, t1, quiet, guard;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0;
        data_a = 16'hA5C3; data_b = 16'h1111; data_c = 16'h2222;
        repeat (3) step();

        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_cs_n", 32'(cs_n_a), 32'd1);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_tick", 32'(tick_a), 32'd0);
        check("rst_ovr",  32'(ovr_a),  32'd0);

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        c0 = cyc;
        wait_tick_a("first_tick_wait");
        check("first_tick_cycle", 32'(cyc - c0 + 1), 32'd101);
        t1 = cyc;

        capture(0, 0, 16'h0000, w, csl, rs, bn, tk);
        check("basic_word",  32'(w),   32'(sent(16'hA5C3)));
        check("basic_cs",    32'(csl), 32'd64);
        check("basic_rises", 32'(rs),  32'd16);
        check("basic_busy",  32'(bn),  32'd66);
        check("basic_ticks", 32'(tk),  32'd0);
        check("basic_ovr",   32'(ovr_a), 32'd0);

        data_a = 16'h1234;
        wait_tick_a("period_wait");
        check("tick_period", 32'(cyc - t1), 32'd100);

        capture(1, 5, 16'hFFFF, w, csl, rs, bn, tk);
        check("stable_word", 32'(w), 32'(sent(16'h1234)));
        capture(0, 0, 16'h0000, w, csl, rs, bn, tk);
        check("next_word",   32'(w), 32'(sent(16'hFFFF)));

        data_a = 16'h0F0F;
        capture(2, 3, 16'h0000, w, csl, rs, bn, tk);
        check("en_word",  32'(w),  32'(sent(16'h0F0F)));
        check("en_busy",  32'(bn), 32'd66);
        check("en_ticks", 32'(tk), 32'd0);
        quiet = 0;
        repeat (150) begin
            step();
            if (tick_a === 1'b1) quiet++;
        end
        check("en_quiet", 32'(quiet), 32'd0);
        en_a = 1'b1;
        c0 = cyc;
        wait_tick_a("reenable_wait");
        check("reenable_cycle", 32'(cyc - c0 + 1), 32'd101);

        data_a = 16'h5A3C;
        capture(3, 7, 16'h0000, w, csl, rs, bn, tk);
        check("rst_mid_at_bit7", 32'(rs), 32'd8);
        step();
        check("rstm_cs_n", 32'(cs_n_a), 32'd1);
        check("rstm_sclk", 32'(sclk_a), 32'd0);
        check("rstm_mosi", 32'(mosi_a), 32'd0);
        check("rstm_busy", 32'(busy_a), 32'd0);
        check("rstm_ovr",  32'(ovr_a),  32'd0);
        rst_a = 1'b0;
        capture(0, 0, 16'h0000, w, csl, rs, bn, tk);
        check("after_rst_word",  32'(w),   32'(sent(16'h5A3C)));
        check("after_rst_rises", 32'(rs),  32'd16);
        check("after_rst_cs",    32'(csl), 32'd64);

        data_a = 16'h8000;
        capture(0, 0, 16'h0000, w, csl, rs, bn, tk);
        check("fmt_8000", 32'(w), 32'(sent(16'h8000)));
        data_a = 16'h7FFF;
        capture(0, 0, 16'h0000, w, csl, rs, bn, tk);
        check("fmt_7fff", 32'(w), 32'(sent(16'h7FFF)));

        guard = 0;
        while (ticks_b < 21 && guard < 3000) begin
            step();
            guard++;
        end
        repeat (100) step();
        check("ovr_b_ticks_reached", 32'(guard < 3000), 32'd1);
        check("ovr_b_ten",  32'(ovr_b), 32'd10);
        check("ovr_c_sat",  32'(ovr_c), 32'd3);
        check("ovr_a_none", 32'(ovr_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Paced serial transmitter sitting directly downstream of the Nios system's 16-bit DAC output port.
- Samples the parallel DAC word at a fixed programmable rate.
- Shifts each sample MSB-first to an external SPI DAC (SPI mode 0, CS-framed).
- Reports busy status and a saturating count of sample ticks dropped because a frame was still in flight.

Parameters:
- DATA_W, 16, sample width and bits per SPI frame.
- CLK_DIV, 2, SCLK half-period in clk_clk cycles (>=1).
- SAMPLE_DIV, 1000, sample period in clk_clk cycles (>=2); 50 kHz at 50 MHz.
- OVR_W, 8, width of overrun counter.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  run sample timer; low holds timer at 0.
- dac_data  in  DATA_W  parallel sample from Nios DAC export.
- dac_sclk  out  1  SPI clock, idle low.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_mosi  out  1  serial data, MSB first.
- busy  out  1  high whenever state != IDLE.
- sample_tick  out  1  one-cycle pulse per sample period.
- overrun_cnt  out  OVR_W  saturating count of dropped ticks.

Behaviour:
- Clock and reset: one clock (clk_clk). Reset is synchronous and active-high (reset_reset).
- Reset values: dac_sclk=0, dac_cs_n=1, dac_mosi=0, busy=0, sample_tick=0, overrun_cnt=0, timer=0, state=IDLE.
- Reset mid-frame: all outputs return to these values on the next edge. There is no frame completion.
- Timer:
  - While enable=1, counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick is registered and high in the cycle after the timer holds SAMPLE_DIV-1.
  - enable=0 clears the timer, so no further ticks occur. An in-progress frame still completes.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD.
- IDLE:
  - On sample_tick=1, next edge: latch dac_data into the shift register, drive dac_cs_n=0, drive dac_mosi=dac_data[DATA_W-1], go to SETUP.
  - dac_data changes after latching do not affect the frame.
- SETUP: CLK_DIV cycles with sclk=0, then go to SHIFT_HI.
- SHIFT_HI: sclk=1 for CLK_DIV cycles (DAC samples on the rising edge).
  - If this is bit DATA_W-1, go to HOLD.
  - Otherwise go to SHIFT_LO.
- SHIFT_LO:
  - On entry, sclk=0; shift the register left by one and drive mosi with the next bit.
  - Lasts CLK_DIV cycles, then go to SHIFT_HI.
- HOLD: sclk=0, cs_n=1, mosi=0 for CLK_DIV cycles, then go to IDLE.
- Frame timing: cs_n low for 2*DATA_W*CLK_DIV cycles; busy high for (2*DATA_W+1)*CLK_DIV cycles. With defaults: 64 and 66.
- Overrun: sample_tick while state != IDLE drops the sample, and overrun_cnt increments, saturating at all-ones. A tick coinciding with the HOLD->IDLE transition edge is also dropped.
- Simultaneous reset and tick: reset wins.
- Bit counter: width clog2(DATA_W), counts 0..DATA_W-1, no wrap beyond.

Optional Feature:
- Macro: DAC_SPI_TX_OFFSET_BINARY_EN.
- Defined: the latched word has its MSB inverted (two's complement to offset binary) before shifting; 16'h8000 is sent as 16'h0000 and 16'h7FFF as 16'hFFFF.
- Undefined: the word is sent unmodified.
- The macro affects no timing and no other output.

Decomposition:
- Package dac_spi_pkg:
  - state enum (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD).
  - localparam function for frame length, (2*DATA_W+1)*CLK_DIV.
- Sub-module dac_sample_timer:
  - Parameter SAMPLE_DIV; ports clk_clk, reset_reset, enable, sample_tick.
  - Instantiated once.
- FSM, shift register, half-period counter and overrun counter stay in the top.

Test Plan (all with CLK_DIV=2):
- Basic frame: SAMPLE_DIV=100, dac_data=16'hA5C3, enable=1 -> cs_n low exactly 64 cycles, 16 sclk rising edges, MOSI captured on rising edges = 16'hA5C3, busy 66 cycles, sample_tick every 100 cycles, overrun_cnt=0.
- Overrun: SAMPLE_DIV=50 -> ticks at 50, 150, ... dropped and frames start on ticks at 0, 100, 200; after 10 dropped ticks overrun_cnt=10. Separately, with OVR_W=2, verify saturation at 3.
- Data stability: change dac_data from 16'h1234 to 16'hFFFF at bit 5 of a frame -> serialized word remains 16'h1234; the next frame sends 16'hFFFF.
- Reset mid-frame: assert reset_reset for 1 cycle at bit 7 -> next edge cs_n=1, sclk=0, mosi=0, busy=0, overrun_cnt=0. The next tick sends a complete 16-bit frame.
- Enable gating: drop enable at bit 3 -> the frame completes normally and no sample_tick occurs while low. Re-enable -> first tick after SAMPLE_DIV+1 cycles.
- Optional feature built in, dac_data=16'h8000 then 16'h7FFF -> serialized 16'h0000 then 16'hFFFF. Feature built out -> serialized 16'h8000 and 16'h7FFF.
